cpu7_exu_wbq: RTL and testbench

CPU7_EXU_WBQ -- requirements
Module: cpu7_exu_wbq

---
 rtl/cpu7_exu_wbq_pkg.sv | 13 +
 rtl/cpu7_exu_wbq_ptr.sv | 29 ++
 rtl/cpu7_exu_wbq.sv | 99 +++++++++
 tb/tb_cpu7_exu_wbq.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/cpu7_exu_wbq_pkg.sv
// Shared widths and the writeback queue entry layout for the execute-unit writeback queue.
package cpu7_exu_wbq_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;

  typedef struct packed {
    logic                 valid;
    logic [RF_ADDR_W-1:0] waddr;
    logic [RF_DATA_W-1:0] wdata;
  } wbq_entry_t;

endpackage

// File: rtl/cpu7_exu_wbq_ptr.sv
// Head/tail pointers and occupancy count for the writeback queue; 0..2 moves per side per cycle.
module cpu7_exu_wbq_ptr #(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [1:0]    enq_cnt,
  input  logic [1:0]    deq_cnt,
  output logic [PW-1:0] head,
  output logic [PW-1:0] tail,
  output logic [CW-1:0] count
);

  // Truncation to PW bits gives the modulo-DEPTH wrap for free.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(deq_cnt);
      tail  <= tail + PW'(enq_cnt);
      count <= count + CW'(enq_cnt) - CW'(deq_cnt);
    end
  end

endmodule

// File: rtl/cpu7_exu_wbq.sv
// Dual-port in-order writeback queue: accepts up to two results per cycle and retires the
// head pair to the register file in the following cycle, unconditionally.
module cpu7_exu_wbq
  import cpu7_exu_wbq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 in0_valid,
  output logic                 in0_ready,
  input  logic [RF_ADDR_W-1:0] in0_waddr,
  input  logic [RF_DATA_W-1:0] in0_wdata,
  input  logic                 in1_valid,
  output logic                 in1_ready,
  input  logic [RF_ADDR_W-1:0] in1_waddr,
  input  logic [RF_DATA_W-1:0] in1_wdata,
  output logic                 wen1,
  output logic [RF_ADDR_W-1:0] waddr1,
  output logic [RF_DATA_W-1:0] wdata1,
  output logic                 wen2,
  output logic [RF_ADDR_W-1:0] waddr2,
  output logic [RF_DATA_W-1:0] wdata2,
  output logic [31:0]          pend_mask,
  output logic                 empty,
  output logic                 full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  wbq_entry_t    q [DEPTH];
  logic [PW-1:0] head, tail, head1, tail1;
  logic [CW-1:0] count;
  logic          in0_xfer, in1_xfer, wr0, wr1;
  logic [1:0]    enq_cnt, deq_cnt;
  wbq_entry_t    ent0, ent1, new0, new1;

  cpu7_exu_wbq_ptr #(.DEPTH(DEPTH)) u_ptr (
    .clk     (clk),
    .resetn  (resetn),
    .enq_cnt (enq_cnt),
    .deq_cnt (deq_cnt),
    .head    (head),
    .tail    (tail),
    .count   (count)
  );

  assign head1 = head + PW'(1);
  assign tail1 = tail + PW'(1);
  assign ent0  = q[head];
  assign ent1  = q[head1];

  // Readiness looks only at the registered count, so same-cycle drains never widen it.
  assign in0_ready = (count < DEPTH_C);
  assign in1_ready = (count < (DEPTH_C - CW'(1)));
  assign in0_xfer  = in0_valid & in0_ready;
  assign in1_xfer  = in1_valid & in1_ready;
  assign enq_cnt   = {1'b0, in0_xfer} + {1'b0, in1_xfer};
  assign deq_cnt   = {1'b0, ent0.valid} + {1'b0, ent1.valid};

  // A lone in1 transfer takes the tail slot; with both, in0 is older and goes first.
  assign wr0  = in0_xfer | in1_xfer;
  assign wr1  = in0_xfer & in1_xfer;
  assign new0 = in0_xfer ? {1'b1, in0_waddr, in0_wdata} : {1'b1, in1_waddr, in1_wdata};
  assign new1 = {1'b1, in1_waddr, in1_wdata};

  // Enqueue slots are always free and drain slots always valid, so they never collide.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) q[i].valid <= 1'b0;
    end else begin
      if (ent0.valid) q[head].valid  <= 1'b0;
      if (ent1.valid) q[head1].valid <= 1'b0;
      if (wr0)        q[tail]        <= new0;
      if (wr1)        q[tail1]       <= new1;
    end
  end

  assign wen1   = ent0.valid && (ent0.waddr != '0);
  assign waddr1 = ent0.valid ? ent0.waddr : '0;
  assign wdata1 = ent0.valid ? ent0.wdata : '0;
  assign wen2   = ent1.valid && (ent1.waddr != '0);
  assign waddr2 = ent1.valid ? ent1.waddr : '0;
  assign wdata2 = ent1.valid ? ent1.wdata : '0;

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q[i].valid) pend_mask[q[i].waddr] = 1'b1;
    end
    pend_mask[0] = 1'b0;
  end

  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);

endmodule

// File: tb/tb_cpu7_exu_wbq.sv
// Directed bench for the writeback queue: a DEPTH=4 instance plus a DEPTH=2 instance on the
// same inputs to reach the ready/full boundaries that unconditional draining allows.
module tb_cpu7_exu_wbq;
  import cpu7_exu_wbq_pkg::*;

  logic                 clk = 1'b0;
  logic                 resetn = 1'b0;
  logic                 in0_valid = 1'b0, in1_valid = 1'b0;
  logic [RF_ADDR_W-1:0] in0_waddr = '0, in1_waddr = '0;
  logic [RF_DATA_W-1:0] in0_wdata = '0, in1_wdata = '0;

  logic                 in0_ready, in1_ready, wen1, wen2, empty, full;
  logic [RF_ADDR_W-1:0] waddr1, waddr2;
  logic [RF_DATA_W-1:0] wdata1, wdata2;
  logic [31:0]          pend_mask;

  logic                 in0_ready_d2, in1_ready_d2, wen1_d2, wen2_d2, empty_d2, full_d2;
  logic [RF_ADDR_W-1:0] waddr1_d2, waddr2_d2;
  logic [RF_DATA_W-1:0] wdata1_d2, wdata2_d2;
  logic [31:0]          pend_mask_d2;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  int snap;
  logic [31:0] rf [32];

  always #5 clk = ~clk;

  cpu7_exu_wbq #(.DEPTH(4)) u_dut (
    .clk(clk), .resetn(resetn),
    .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_waddr(in0_waddr), .in0_wdata(in0_wdata),
    .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_waddr(in1_waddr), .in1_wdata(in1_wdata),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .wen2(wen2), .waddr2(waddr2), .wdata2(wdata2),
    .pend_mask(pend_mask), .empty(empty), .full(full)
  );

  cpu7_exu_wbq #(.DEPTH(2)) u_dut2 (
    .clk(clk), .resetn(resetn),
    .in0_valid(in0_valid), .in0_ready(in0_ready_d2), .in0_waddr(in0_waddr), .in0_wdata(in0_wdata),
    .in1_valid(in1_valid), .in1_ready(in1_ready_d2), .in1_waddr(in1_waddr), .in1_wdata(in1_wdata),
    .wen1(wen1_d2), .waddr1(waddr1_d2), .wdata1(wdata1_d2),
    .wen2(wen2_d2), .waddr2(waddr2_d2), .wdata2(wdata2_d2),
    .pend_mask(pend_mask_d2), .empty(empty_d2), .full(full_d2)
  );

  // Register-file model: port 2 is written after port 1, so it wins on equal addresses.
  always @(posedge clk) begin
    if (resetn) begin
      if (wen1) rf[waddr1] <= wdata1;
      if (wen2) rf[waddr2] <= wdata2;
      wr_cnt <= wr_cnt + int'(wen1) + int'(wen2);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_in0_ready", 32'(in0_ready), 32'd1);
    chk("rst_in1_ready", 32'(in1_ready), 32'd1);
    chk("rst_wen1", 32'(wen1), 32'd0);
    chk("rst_wen2", 32'(wen2), 32'd0);
    chk("rst_waddr1", 32'(waddr1), 32'd0);
    chk("rst_wdata1", wdata1, 32'd0);
    chk("rst_pend", pend_mask, 32'd0);
    resetn = 1'b1;

    // Single enqueue on in0
    @(posedge clk); #1;
    in0_valid = 1'b1; in0_waddr = 5'd5; in0_wdata = 32'h1122_3344;
    @(posedge clk); #1;
    in0_valid = 1'b0;
    @(negedge clk);
    chk("single_wen1", 32'(wen1), 32'd1);
    chk("single_waddr1", 32'(waddr1), 32'd5);
    chk("single_wdata1", wdata1, 32'h1122_3344);
    chk("single_wen2", 32'(wen2), 32'd0);
    chk("single_pend", pend_mask, 32'h0000_0020);
    chk("single_empty", 32'(empty), 32'd0);
    chk("d2_one_in0_ready", 32'(in0_ready_d2), 32'd1);
    chk("d2_one_in1_ready", 32'(in1_ready_d2), 32'd0);
    chk("d2_one_full", 32'(full_d2), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("single_after_empty", 32'(empty), 32'd1);
    chk("single_after_wen1", 32'(wen1), 32'd0);
    chk("single_after_pend", pend_mask, 32'd0);
    chk("rf5", rf[5], 32'h1122_3344);

    // Dual enqueue to the same register
    @(posedge clk); #1;
    in0_valid = 1'b1; in0_waddr = 5'd7; in0_wdata = 32'hA;
    in1_valid = 1'b1; in1_waddr = 5'd7; in1_wdata = 32'hB;
    @(posedge clk); #1;
    in0_valid = 1'b0; in1_valid = 1'b0;
    @(negedge clk);
    chk("dual_wen1", 32'(wen1), 32'd1);
    chk("dual_waddr1", 32'(waddr1), 32'd7);
    chk("dual_wdata1", wdata1, 32'hA);
    chk("dual_wen2", 32'(wen2), 32'd1);
    chk("dual_waddr2", 32'(waddr2), 32'd7);
    chk("dual_wdata2", wdata2, 32'hB);
    chk("dual_pend", pend_mask, 32'h0000_0080);
    chk("dual_in0_ready", 32'(in0_ready), 32'd1);
    chk("dual_in1_ready", 32'(in1_ready), 32'd1);
    chk("dual_full", 32'(full), 32'd0);
    chk("d2_full", 32'(full_d2), 32'd1);
    chk("d2_full_in0_ready", 32'(in0_ready_d2), 32'd0);
    chk("d2_full_in1_ready", 32'(in1_ready_d2), 32'd0);
    chk("d2_full_wdata2", wdata2_d2, 32'hB);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rf7_younger_wins", rf[7], 32'hB);
    chk("dual_after_empty", 32'(empty), 32'd1);
    chk("d2_after_empty", 32'(empty_d2), 32'd1);

    // waddr 0 entry drains without a write
    snap = wr_cnt;
    @(posedge clk); #1;
    in0_valid = 1'b1; in0_waddr = 5'd0; in0_wdata = 32'h0000_FFFF;
    @(posedge clk); #1;
    in0_valid = 1'b0;
    @(negedge clk);
    chk("zero_wen1", 32'(wen1), 32'd0);
    chk("zero_pend", pend_mask, 32'd0);
    chk("zero_empty", 32'(empty), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("zero_after_empty", 32'(empty), 32'd1);
    chk("zero_no_write", 32'(wr_cnt), 32'(snap));

    // Continuous dual enqueue across pointer wrap
    for (int k = 0; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k < 10) begin
        in0_valid = 1'b1; in0_waddr = 5'(k + 1);  in0_wdata = 32'h100 + 32'(2 * k);
        in1_valid = 1'b1; in1_waddr = 5'(k + 11); in1_wdata = 32'h101 + 32'(2 * k);
      end else begin
        in0_valid = 1'b0; in1_valid = 1'b0;
      end
      @(negedge clk);
      if (k > 0) begin
        chk($sformatf("wrap_wdata1_%0d", k - 1), wdata1, 32'h100 + 32'(2 * (k - 1)));
        chk($sformatf("wrap_wdata2_%0d", k - 1), wdata2, 32'h101 + 32'(2 * (k - 1)));
        chk($sformatf("wrap_wens_%0d", k - 1), {30'd0, wen1, wen2}, 32'd3);
        chk($sformatf("wrap_pend_%0d", k - 1), pend_mask, (32'd1 << k) | (32'd1 << (k + 10)));
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("wrap_after_empty", 32'(empty), 32'd1);
    chk("wrap_rf20", rf[20], 32'h113);

    // Reset mid-operation
    @(posedge clk); #1;
    in0_valid = 1'b1; in0_waddr = 5'd3; in0_wdata = 32'h33;
    in1_valid = 1'b1; in1_waddr = 5'd4; in1_wdata = 32'h44;
    @(posedge clk); #1;
    in1_valid = 1'b0; in0_waddr = 5'd9; in0_wdata = 32'h99;
    @(negedge clk);
    chk("pre_rst_pend", pend_mask, 32'h0000_0018);
    resetn = 1'b0;
    #1;
    chk("midrst_wen1", 32'(wen1), 32'd0);
    chk("midrst_wen2", 32'(wen2), 32'd0);
    chk("midrst_empty", 32'(empty), 32'd1);
    chk("midrst_pend", pend_mask, 32'd0);
    in0_valid = 1'b0;
    snap = wr_cnt;
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_no_write", 32'(wr_cnt), 32'(snap));
    chk("post_rst_empty", 32'(empty), 32'd1);
    chk("post_rst_wen1", 32'(wen1), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
